multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the LEGv8 datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over shared ALU, register file and memory ports.
- Drives the same control strobes as the single-cycle decoder, plus PC/IR write enables and memory request handshakes.
- Sits between the instruction register (opcode bits 31:21) and the datapath.
- Memory waits are bounded by a timeout that traps to a sticky fault state.

Parameters:
MAX_WAIT, 8, max cycles a memory request may wait for ready before FAULT (legal range 2..255)
CNT_W, 8, width of the wait counter; must hold MAX_WAIT-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  11  opcode field instr[31:21] from the IR; valid from the DECODE cycle onward
imem_ready  in  1  instruction memory has data; IR captures on ir_write
dmem_ready  in  1  data memory completed the current read/write
zero  in  1  ALU zero flag, valid in EXEC
imem_req  out  1  instruction fetch request
ir_write  out  1  IR load enable (1-cycle pulse)
pc_write  out  1  PC update enable (1-cycle pulse, once per retired instruction)
pc_src  out  1  1 = branch target, 0 = PC+4; meaningful only with pc_write
reg2loc, AluSrc, memtoReg, regWrite, memRead, memWrite  out  1 each  datapath strobes
AluControl  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
fault  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- Decoded classes (latched in DECODE):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → RTYPE
  - LDUR 11111000010 → LOAD
  - STUR 11111000000 → STORE
  - CBZ 10110100xxx → CBZ
  - anything else → ILLEGAL
- State register: FETCH, DECODE, EXEC, MEM, WB, FAULT. Plus latched class/ALU-op register and wait counter. All asynchronously reset.
- Reset:
  - State = FETCH, counter = 0, class = RTYPE, fault = 0.
  - Every output is 0 while reset is high, including imem_req.
  - Reset asserted in any state, including mid-MEM, aborts with no pc_write or regWrite. First cycle after release is FETCH.
- FETCH:
  - imem_req = 1.
  - imem_ready = 1: ir_write = 1 (same cycle), counter ← 0, → DECODE.
  - Otherwise counter + 1; if counter == MAX_WAIT-1 and no ready → FAULT.
- DECODE:
  - Latch class and AluControl value from instr.
  - reg2loc = 1 for STUR and CBZ.
  - ILLEGAL → FAULT; else → EXEC.
- EXEC:
  - AluControl driven from the latch. RTYPE uses its op; LOAD/STORE use ADD; CBZ uses pass-B.
  - AluSrc = 1 for LOAD/STORE; reg2loc held for STORE/CBZ.
  - RTYPE → WB. LOAD/STORE → MEM (counter ← 0).
  - CBZ: pc_write = 1, pc_src = zero, → FETCH.
- MEM:
  - memRead = 1 (LOAD) or memWrite = 1 (STORE), held every cycle until dmem_ready. AluSrc and AluControl held.
  - STORE with dmem_ready: pc_write = 1, pc_src = 0, → FETCH.
  - LOAD with dmem_ready: → WB.
  - Timeout rule identical to FETCH.
- WB:
  - regWrite = 1; memtoReg = 1 for LOAD.
  - RTYPE holds AluControl and AluSrc = 0.
  - pc_write = 1, pc_src = 0, → FETCH.
- FAULT:
  - fault = 1. All strobes, requests and enables are 0.
  - Exit only by reset.
- Output timing:
  - Strobes are combinational from state + latched class.
  - ir_write, and MEM-state exits, are combinational from ready inputs; no extra cycle.
- Pulse rules:
  - pc_write asserts exactly once per non-faulting instruction.
  - memRead and memWrite are never high together.
  - regWrite and memWrite are never high together.
- Latency with zero wait states (cycles from FETCH entry to pc_write cycle, inclusive):
  - RTYPE 4, LOAD 5, STORE 4, CBZ 3.
  - Each wait cycle adds 1.
- A ready input arriving in a state that does not request it is ignored.

Test Plan:
- ADD opcode, imem_ready tied 1 → ir_write cycle 1; AluControl=0010 in EXEC; regWrite=1 and pc_write=1 only in cycle 4; back in FETCH cycle 5.
- LDUR, dmem_ready low 2 cycles → memRead held 3 cycles, AluControl=0010, AluSrc=1; WB cycle with regWrite=1 and memtoReg=1; pc_write at cycle 7.
- STUR, immediate ready → memWrite one cycle, reg2loc=1, regWrite never 1, pc_write with pc_src=0 at cycle 4.
- CBZ with zero=1, then a second CBZ with zero=0 → pc_write in cycle 3 both times; pc_src=1 then 0; AluControl=0111.
- Illegal opcode 00000000000 → fault=1 from the cycle after DECODE, all strobes 0 for 20 cycles; reset clears fault and imem_req reappears.
- MAX_WAIT=8, dmem_ready stuck 0 during LDUR MEM → FAULT after 8 MEM cycles with no regWrite/pc_write; separately, reset pulsed mid-MEM → no pc_write, restart in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// bounded memory waits that trap to a sticky FAULT state.
module multicycle_ctrl #(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        zero,
   output logic        imem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg2loc,
   output logic        AluSrc,
   output logic        memtoReg,
   output logic        regWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic [3:0]  AluControl,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_FAULT
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE,
      C_LOAD,
      C_STORE,
      C_CBZ,
      C_ILL
   } cls_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

   state_t           state_q, state_d;
   cls_t             cls_q, cls_d;
   logic [3:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   cls_t       dec_cls;
   logic [3:0] dec_op;
   logic       wait_exp;

   always_comb begin
      dec_cls = C_ILL;
      dec_op  = 4'b0000;
      casez (instr)
         11'b10001011000: begin dec_cls = C_RTYPE; dec_op = 4'b0010; end
         11'b11001011000: begin dec_cls = C_RTYPE; dec_op = 4'b0110; end
         11'b10001010000: begin dec_cls = C_RTYPE; dec_op = 4'b0000; end
         11'b10101010000: begin dec_cls = C_RTYPE; dec_op = 4'b0001; end
         11'b11111000010: begin dec_cls = C_LOAD;  dec_op = 4'b0010; end
         11'b11111000000: begin dec_cls = C_STORE; dec_op = 4'b0010; end
         11'b10110100???: begin dec_cls = C_CBZ;   dec_op = 4'b0111; end
         default: ;
      endcase
   end

   assign wait_exp = (cnt_q == LAST);

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      op_d       = op_q;
      cnt_d      = '0;
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      AluSrc     = 1'b0;
      memtoReg   = 1'b0;
      regWrite   = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      AluControl = 4'b0000;
      fault      = 1'b0;
      // Outputs stay quiet while reset is held, even though state reads FETCH
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (wait_exp) begin
                  state_d = S_FAULT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DECODE: begin
               cls_d   = dec_cls;
               op_d    = dec_op;
               reg2loc = (dec_cls == C_STORE) || (dec_cls == C_CBZ);
               state_d = (dec_cls == C_ILL) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
               AluControl = op_q;
               case (cls_q)
                  C_RTYPE: state_d = S_WB;
                  C_LOAD: begin
                     AluSrc  = 1'b1;
                     state_d = S_MEM;
                  end
                  C_STORE: begin
                     AluSrc  = 1'b1;
                     reg2loc = 1'b1;
                     state_d = S_MEM;
                  end
                  C_CBZ: begin
                     reg2loc  = 1'b1;
                     pc_write = 1'b1;
                     pc_src   = zero;
                     state_d  = S_FETCH;
                  end
                  default: state_d = S_FAULT;
               endcase
            end
            S_MEM: begin
               AluSrc     = 1'b1;
               AluControl = op_q;
               reg2loc    = (cls_q == C_STORE);
               memRead    = (cls_q == C_LOAD);
               memWrite   = (cls_q == C_STORE);
               if (dmem_ready) begin
                  if (cls_q == C_STORE) begin
                     pc_write = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end else if (wait_exp) begin
                  state_d = S_FAULT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WB: begin
               regWrite = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
               if (cls_q == C_LOAD) memtoReg = 1'b1;
               else AluControl = op_q;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cls_q   <= C_RTYPE;
         op_q    <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected traces are queued
// cycle by cycle and compared against the DUT on every falling edge.
module tb_multicycle_ctrl;

   localparam int MAXW = 8;

   typedef struct packed {
      logic       imem_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg2loc;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] alu_ctl;
      logic       fault;
   } out_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] instr = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        zero = 1'b0;
   logic        imem_req, ir_write, pc_write, pc_src, reg2loc, AluSrc;
   logic        memtoReg, regWrite, memRead, memWrite, fault;
   logic [3:0]  AluControl;

   int tests = 0;
   int fails = 0;
   int pcw_seen = 0;

   out_t  expq[$];
   string tagq[$];

   multicycle_ctrl #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .reg2loc(reg2loc), .AluSrc(AluSrc),
      .memtoReg(memtoReg), .regWrite(regWrite), .memRead(memRead),
      .memWrite(memWrite), .AluControl(AluControl), .fault(fault)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      out_t got, e;
      string t;
      got = {imem_req, ir_write, pc_write, pc_src, reg2loc, AluSrc,
             memtoReg, regWrite, memRead, memWrite, AluControl, fault};
      if (pc_write) pcw_seen++;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         t = tagq.pop_front();
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL %s got %b want %b", t, got, e);
         end
      end
   end

   task automatic cyc(input logic r, input logic ir, input logic dr,
                      input logic z, input logic [10:0] op,
                      input out_t e, input string tag);
      @(posedge clk);
      #1;
      reset      = r;
      imem_ready = ir;
      dmem_ready = dr;
      zero       = z;
      instr      = op;
      expq.push_back(e);
      tagq.push_back(tag);
   endtask

   task automatic do_reset(input int n, input string nm);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, nm);
   endtask

   task automatic faults(input int n, input string nm);
      out_t e;
      e = '0;
      e.fault = 1'b1;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, '0, e, nm);
   endtask

   // 0 rtype, 1 load, 2 store, 3 cbz, 4 illegal
   function automatic int cls_of(input logic [10:0] op,
                                 output logic [3:0] aop);
      aop = 4'b0000;
      if (op == 11'b10001011000) begin aop = 4'b0010; return 0; end
      if (op == 11'b11001011000) begin aop = 4'b0110; return 0; end
      if (op == 11'b10001010000) begin aop = 4'b0000; return 0; end
      if (op == 11'b10101010000) begin aop = 4'b0001; return 0; end
      if (op == 11'b11111000010) begin aop = 4'b0010; return 1; end
      if (op == 11'b11111000000) begin aop = 4'b0010; return 2; end
      if (op[10:3] == 8'b10110100) begin aop = 4'b0111; return 3; end
      return 4;
   endfunction

   task automatic run_instr(input string nm, input logic [10:0] op,
                            input int fw, input int mw, input logic z,
                            input int abort_at, output int lat);
      out_t e;
      int c, k;
      logic [3:0] aop;
      logic ld, st, cb;
      k  = cls_of(op, aop);
      ld = (k == 1);
      st = (k == 2);
      cb = (k == 3);
      lat = -1;
      c = 0;
      for (int i = 0; i < fw && i < MAXW; i++) begin
         e = '0;
         e.imem_req = 1'b1;
         cyc(1'b0, 1'b0, 1'b1, z, op, e, {nm, "/fetchwait"});
         c++;
      end
      if (fw >= MAXW) begin
         faults(6, {nm, "/fetchto"});
         return;
      end
      e = '0;
      e.imem_req = 1'b1;
      e.ir_write = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/fetch"});
      c++;
      e = '0;
      e.reg2loc = st | cb;
      cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/decode"});
      c++;
      if (k == 4) begin
         faults(20, {nm, "/fault"});
         return;
      end
      e = '0;
      e.alu_ctl = aop;
      e.alu_src = ld | st;
      e.reg2loc = st | cb;
      if (cb) begin
         e.pc_write = 1'b1;
         e.pc_src   = z;
         cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/branch"});
         c++;
         lat = c;
         return;
      end
      cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/exec"});
      c++;
      if (ld | st) begin
         e = '0;
         e.mem_read  = ld;
         e.mem_write = st;
         e.alu_src   = 1'b1;
         e.alu_ctl   = 4'b0010;
         e.reg2loc   = st;
         for (int i = 0; i < mw && i < MAXW; i++) begin
            if (i == abort_at) begin
               do_reset(1, {nm, "/abort"});
               return;
            end
            cyc(1'b0, 1'b1, 1'b0, z, op, e, {nm, "/memwait"});
            c++;
         end
         if (mw >= MAXW) begin
            faults(6, {nm, "/memto"});
            return;
         end
         e.pc_write = st;
         cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/mem"});
         c++;
         if (st) begin
            lat = c;
            return;
         end
      end
      e = '0;
      e.reg_write  = 1'b1;
      e.pc_write   = 1'b1;
      e.mem_to_reg = ld;
      e.alu_ctl    = ld ? 4'b0000 : aop;
      cyc(1'b0, 1'b1, 1'b1, z, op, e, {nm, "/wb"});
      c++;
      lat = c;
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   initial begin
      int lat;
      do_reset(3, "reset");
      run_instr("add", 11'b10001011000, 0, 0, 1'b1, -1, lat);
      check_int("lat_add", lat, 4);
      run_instr("sub", 11'b11001011000, 1, 0, 1'b0, -1, lat);
      check_int("lat_sub_w1", lat, 5);
      run_instr("and", 11'b10001010000, 0, 0, 1'b0, -1, lat);
      run_instr("orr", 11'b10101010000, 0, 0, 1'b1, -1, lat);
      run_instr("ldur", 11'b11111000010, 0, 2, 1'b1, -1, lat);
      check_int("lat_ldur_w2", lat, 7);
      run_instr("stur", 11'b11111000000, 0, 0, 1'b1, -1, lat);
      check_int("lat_stur", lat, 4);
      run_instr("cbz1", 11'b10110100000, 0, 0, 1'b1, -1, lat);
      check_int("lat_cbz1", lat, 3);
      run_instr("cbz0", 11'b10110100101, 0, 0, 1'b0, -1, lat);
      check_int("lat_cbz0", lat, 3);
      run_instr("stur_w1", 11'b11111000000, 0, 1, 1'b0, -1, lat);
      check_int("lat_stur_w1", lat, 5);
      run_instr("illegal", 11'b00000000000, 0, 0, 1'b0, -1, lat);
      do_reset(2, "rst_ill");
      run_instr("add2", 11'b10001011000, 0, 0, 1'b0, -1, lat);
      check_int("lat_add2", lat, 4);
      run_instr("ldur_to", 11'b11111000010, 0, MAXW, 1'b0, -1, lat);
      do_reset(2, "rst_to");
      run_instr("ldur_ab", 11'b11111000010, 0, 5, 1'b0, 2, lat);
      run_instr("add3", 11'b10001011000, 0, 0, 1'b0, -1, lat);
      check_int("lat_add3", lat, 4);
      run_instr("fetch_to", 11'b10001011000, MAXW, 0, 1'b0, -1, lat);
      do_reset(2, "rst_fto");
      @(negedge clk);
      @(negedge clk);
      check_int("pc_write_count", pcw_seen, 11);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
